// File: rtl/cajero_pkg.sv
// Shared types and helpers for the parametrised ATM controller.
package cajero_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECIBIENDO_PIN,
        COMPARAR_PIN,
        ESPERA_MONTO,
        TRANSACCION,
        BLOQUEO
    } estado_t;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Ceiling log2, elaboration-time only; callers guarantee valor >= 2.
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cajero_pin_shift.sv
// MSB-first BCD digit shift register with digit counter; pin_completo_o flags
// the strobe that delivers the last digit (counter wraps to 0 on that strobe).
module cajero_pin_shift
    import cajero_pkg::*;
#(
    parameter int N_DIGITOS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   limpiar_i,
    input  logic                   digito_stb_i,
    input  logic [3:0]             digito_i,
    output logic [4*N_DIGITOS-1:0] pin_recibido_o,
    output logic                   pin_completo_o
);

    localparam int ANCHO_CNT = clog2(N_DIGITOS);
    localparam logic [ANCHO_CNT-1:0] ULTIMO = ANCHO_CNT'(N_DIGITOS - 1);

    logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
    logic [4*N_DIGITOS-1:0] shift_q, shift_d;

    assign pin_completo_o = digito_stb_i && !limpiar_i && (cnt_q == ULTIMO);
    assign pin_recibido_o = shift_q;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (limpiar_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (digito_stb_i) begin
            shift_d = {shift_q[4*N_DIGITOS-5:0], digito_i};
            cnt_d   = pin_completo_o ? '0 : cnt_q + ANCHO_CNT'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/cajero_param.sv
// Parametrised ATM transaction controller: PIN entry/compare, attempt lockout,
// deposit/withdrawal on a registered balance. CAJERO_LIMITE_RETIRO_EN adds a per-withdrawal cap.
module cajero_param
    import cajero_pkg::*;
#(
    parameter int N_DIGITOS     = 4,
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32,
    parameter int MAX_INTENTOS  = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tarjeta_recibida,
    input  logic                     tipo_trans,
    input  logic                     digito_stb,
    input  logic [3:0]               digito,
    input  logic [4*N_DIGITOS-1:0]   pin,
    input  logic [ANCHO_BALANCE-1:0] balance_inicial,
    input  logic [ANCHO_MONTO-1:0]   monto,
    input  logic                     monto_stb,
`ifdef CAJERO_LIMITE_RETIRO_EN
    input  logic [ANCHO_MONTO-1:0]   limite_retiro,
`endif
    output logic [ANCHO_BALANCE-1:0] balance,
    output logic                     balance_actualizado,
    output logic                     entregar_dinero,
    output logic                     pin_incorrecto,
    output logic                     advertencia,
    output logic                     bloqueo,
    output logic                     fondos_insuficientes
);

    localparam int ANCHO_INT = clog2(MAX_INTENTOS + 1);
    localparam logic [ANCHO_INT-1:0] INT_MAX   = ANCHO_INT'(MAX_INTENTOS);
    localparam logic [ANCHO_INT-1:0] INT_AVISO = ANCHO_INT'(MAX_INTENTOS - 1);

    estado_t                  estado_q;
    logic [ANCHO_INT-1:0]     intentos_q;
    logic [ANCHO_MONTO-1:0]   monto_q;
    logic                     tipo_q;
    logic [ANCHO_BALANCE-1:0] balance_q;
    logic                     actualizado_q, entregar_q, incorrecto_q;
    logic                     advertencia_q, bloqueo_q, fondos_q;

    logic [4*N_DIGITOS-1:0]   pin_recibido;
    logic                     pin_completo;
    logic                     digito_ok;
    logic [ANCHO_INT-1:0]     intentos_sig;
    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic                     retiro_ok;

    // Strobes outside PIN entry, or with the card gone, never reach the shifter.
    assign digito_ok    = (estado_q == RECIBIENDO_PIN) && tarjeta_recibida && digito_stb;
    assign intentos_sig = intentos_q + ANCHO_INT'(1);
    assign monto_ext    = ANCHO_BALANCE'(monto_q);

`ifdef CAJERO_LIMITE_RETIRO_EN
    assign retiro_ok = (monto_ext <= balance_q) && (monto_q <= limite_retiro);
`else
    assign retiro_ok = (monto_ext <= balance_q);
`endif

    cajero_pin_shift #(.N_DIGITOS(N_DIGITOS)) u_pin_shift (
        .clock          (clock),
        .reset          (reset),
        .limpiar_i      (estado_q == IDLE),
        .digito_stb_i   (digito_ok),
        .digito_i       (digito),
        .pin_recibido_o (pin_recibido),
        .pin_completo_o (pin_completo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= IDLE;
            intentos_q    <= '0;
            monto_q       <= '0;
            tipo_q        <= DEPOSITO;
            balance_q     <= '0;
            actualizado_q <= 1'b0;
            entregar_q    <= 1'b0;
            incorrecto_q  <= 1'b0;
            advertencia_q <= 1'b0;
            bloqueo_q     <= 1'b0;
            fondos_q      <= 1'b0;
        end else begin
            actualizado_q <= 1'b0;
            entregar_q    <= 1'b0;
            incorrecto_q  <= 1'b0;
            fondos_q      <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (tarjeta_recibida) begin
                        balance_q <= balance_inicial;
                        estado_q  <= RECIBIENDO_PIN;
                    end
                end
                RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida)  estado_q <= IDLE;
                    else if (pin_completo)  estado_q <= COMPARAR_PIN;
                end
                COMPARAR_PIN: begin
                    if (pin_recibido == pin) begin
                        intentos_q    <= '0;
                        advertencia_q <= 1'b0;
                        estado_q      <= ESPERA_MONTO;
                    end else begin
                        intentos_q   <= intentos_sig;
                        incorrecto_q <= 1'b1;
                        if (intentos_sig == INT_MAX) begin
                            bloqueo_q     <= 1'b1;
                            advertencia_q <= 1'b0;
                            estado_q      <= BLOQUEO;
                        end else begin
                            advertencia_q <= (intentos_sig == INT_AVISO);
                            estado_q      <= RECIBIENDO_PIN;
                        end
                    end
                end
                ESPERA_MONTO: begin
                    if (!tarjeta_recibida) begin
                        estado_q <= IDLE;
                    end else if (monto_stb) begin
                        monto_q  <= monto;
                        tipo_q   <= tipo_trans;
                        estado_q <= TRANSACCION;
                    end
                end
                TRANSACCION: begin
                    if (tipo_q == DEPOSITO) begin
                        balance_q     <= balance_q + monto_ext;
                        actualizado_q <= 1'b1;
                    end else if (retiro_ok) begin
                        balance_q     <= balance_q - monto_ext;
                        actualizado_q <= 1'b1;
                        entregar_q    <= 1'b1;
                    end else begin
                        fondos_q <= 1'b1;
                    end
                    estado_q <= IDLE;
                end
                BLOQUEO: begin
                    bloqueo_q <= 1'b1;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign balance              = balance_q;
    assign balance_actualizado  = actualizado_q;
    assign entregar_dinero      = entregar_q;
    assign pin_incorrecto       = incorrecto_q;
    assign advertencia          = advertencia_q;
    assign bloqueo              = bloqueo_q;
    assign fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_cajero_param.sv
// Directed bench for cajero_param: default instance (A) and a 6-digit, 16-bit instance (B).
module tb_cajero_param;
    import cajero_pkg::*;

    logic clock;
    logic reset;

    logic        tarjeta_a, tipo_a, dstb_a, mstb_a;
    logic [3:0]  dig_a;
    logic [15:0] pin_a;
    logic [63:0] bini_a, bal_a;
    logic [31:0] monto_a;
    logic        act_a, ent_a, inc_a, adv_a, blq_a, fi_a;

    logic        tarjeta_b, tipo_b, dstb_b, mstb_b;
    logic [3:0]  dig_b;
    logic [23:0] pin_b;
    logic [15:0] bini_b, bal_b, monto_b;
    logic        act_b, ent_b, inc_b, adv_b, blq_b, fi_b;

`ifdef CAJERO_LIMITE_RETIRO_EN
    logic [31:0] lim_a;
    logic [15:0] lim_b;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [63:0] ini;
        logic        tipo;
        logic [31:0] monto;
        logic [63:0] fin;
        logic        act;
        logic        ent;
        logic        fi;
    } vec_t;

    vec_t vecs[7];

    cajero_param dut_a (
        .clock(clock), .reset(reset), .tarjeta_recibida(tarjeta_a), .tipo_trans(tipo_a),
        .digito_stb(dstb_a), .digito(dig_a), .pin(pin_a), .balance_inicial(bini_a),
        .monto(monto_a), .monto_stb(mstb_a),
`ifdef CAJERO_LIMITE_RETIRO_EN
        .limite_retiro(lim_a),
`endif
        .balance(bal_a), .balance_actualizado(act_a), .entregar_dinero(ent_a),
        .pin_incorrecto(inc_a), .advertencia(adv_a), .bloqueo(blq_a),
        .fondos_insuficientes(fi_a)
    );

    cajero_param #(.N_DIGITOS(6), .ANCHO_BALANCE(16), .ANCHO_MONTO(16), .MAX_INTENTOS(3)) dut_b (
        .clock(clock), .reset(reset), .tarjeta_recibida(tarjeta_b), .tipo_trans(tipo_b),
        .digito_stb(dstb_b), .digito(dig_b), .pin(pin_b), .balance_inicial(bini_b),
        .monto(monto_b), .monto_stb(mstb_b),
`ifdef CAJERO_LIMITE_RETIRO_EN
        .limite_retiro(lim_b),
`endif
        .balance(bal_b), .balance_actualizado(act_b), .entregar_dinero(ent_b),
        .pin_incorrecto(inc_b), .advertencia(adv_b), .bloqueo(blq_b),
        .fondos_insuficientes(fi_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic digito_a(input logic [3:0] d);
        dig_a  = d;
        dstb_a = 1'b1;
        tick();
        dstb_a = 1'b0;
    endtask

    task automatic digito_b(input logic [3:0] d);
        dig_b  = d;
        dstb_b = 1'b1;
        tick();
        dstb_b = 1'b0;
    endtask

    task automatic pin_seq_a(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) digito_a(p[4*i +: 4]);
    endtask

    // Starts in ESPERA_MONTO; leaves instance A in IDLE with the card out.
    task automatic trans_a(input logic tipo, input logic [31:0] m, input logic [63:0] fin,
                           input logic act, input logic ent, input logic fi, input string n);
        @(negedge clock);
        tipo_a  = tipo;
        monto_a = m;
        mstb_a  = 1'b1;
        dig_a   = 4'h7;
        dstb_a  = 1'b1;
        tick();
        mstb_a = 1'b0;
        dstb_a = 1'b0;
        @(negedge clock);
        chk1({n, " latency1"}, act_a | ent_a | fi_a, 1'b0);
        tick();
        @(negedge clock);
        chk1({n, " actualizado"}, act_a, act);
        chk1({n, " entregar"}, ent_a, ent);
        chk1({n, " fondos"}, fi_a, fi);
        chk({n, " balance"}, bal_a, fin);
        tarjeta_a = 1'b0;
        tick();
        @(negedge clock);
        chk1({n, " pulse_width"}, act_a | ent_a | fi_a, 1'b0);
        chk({n, " balance_hold"}, bal_a, fin);
        tick();
    endtask

    task automatic sesion_a(input vec_t v, input string n);
        bini_a    = v.ini;
        tarjeta_a = 1'b1;
        tick();
        pin_seq_a(16'h1234);
        tick();
        @(negedge clock);
        chk1({n, " pin_ok"}, inc_a, 1'b0);
        trans_a(v.tipo, v.monto, v.fin, v.act, v.ent, v.fi, n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        tarjeta_a = 0; tipo_a = 0; dstb_a = 0; mstb_a = 0; dig_a = 0;
        pin_a = 16'h1234; bini_a = 0; monto_a = 0;
        tarjeta_b = 0; tipo_b = 0; dstb_b = 0; mstb_b = 0; dig_b = 0;
        pin_b = 24'h987654; bini_b = 0; monto_b = 0;
`ifdef CAJERO_LIMITE_RETIRO_EN
        lim_a = 32'hFFFF_FFFF;
        lim_b = 16'hFFFF;
`endif

        vecs[0] = '{64'd1000, DEPOSITO, 32'd250, 64'd1250, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{64'd1000, RETIRO, 32'd1000, 64'd0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{64'd0, RETIRO, 32'd1, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{64'd500, RETIRO, 32'd499, 64'd1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, DEPOSITO, 32'd1, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{64'd10, RETIRO, 32'd11, 64'd10, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{64'd0, DEPOSITO, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("reset A outputs", {58'd0, act_a, ent_a, inc_a, adv_a, blq_a, fi_a}, 64'd0);
        chk("reset A balance", bal_a, 64'd0);
        chk("reset B outputs", {58'd0, act_b, ent_b, inc_b, adv_b, blq_b, fi_b}, 64'd0);
        chk("reset B balance", 64'(bal_b), 64'd0);

        for (int i = 0; i < 7; i++) sesion_a(vecs[i], $sformatf("vec%0d", i));

        // Two wrong PINs, warning on the second, then recovery with the right PIN.
        bini_a    = 64'd1000;
        tarjeta_a = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            pin_seq_a(16'h1235);
            @(negedge clock);
            chk1($sformatf("wrong%0d before_compare", k), inc_a, 1'b0);
            tick();
            @(negedge clock);
            chk1($sformatf("wrong%0d pin_incorrecto", k), inc_a, 1'b1);
            chk1($sformatf("wrong%0d advertencia", k), adv_a, k == 1);
        end
        pin_seq_a(16'h1234);
        tick();
        @(negedge clock);
        chk1("recover pin_incorrecto", inc_a, 1'b0);
        chk1("recover advertencia", adv_a, 1'b0);
        trans_a(DEPOSITO, 32'd250, 64'd1250, 1'b1, 1'b0, 1'b0, "recover");

        // Card pulled after two digits: entry must restart from the first digit.
        bini_a    = 64'd1000;
        tarjeta_a = 1'b1;
        tick();
        digito_a(4'h1);
        digito_a(4'h2);
        tarjeta_a = 1'b0;
        tick();
        tarjeta_a = 1'b1;
        tick();
        pin_seq_a(16'h1234);
        @(negedge clock);
        chk1("reinsert no_early_compare", inc_a, 1'b0);
        tick();
        @(negedge clock);
        chk1("reinsert pin_ok", inc_a, 1'b0);
        trans_a(DEPOSITO, 32'd5, 64'd1005, 1'b1, 1'b0, 1'b0, "reinsert");

`ifdef CAJERO_LIMITE_RETIRO_EN
        lim_a = 32'd500;
        sesion_a('{64'd1000, RETIRO, 32'd600, 64'd1000, 1'b0, 1'b0, 1'b1}, "limit_over");
        sesion_a('{64'd1000, RETIRO, 32'd500, 64'd500, 1'b1, 1'b1, 1'b0}, "limit_equal");
        sesion_a('{64'd1000, DEPOSITO, 32'd600, 64'd1600, 1'b1, 1'b0, 1'b0}, "limit_deposit");
        lim_a = 32'hFFFF_FFFF;
`endif

        // Three wrong PINs lock the card out until reset.
        bini_a    = 64'd1000;
        tarjeta_a = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            pin_seq_a(16'h1235);
            tick();
            @(negedge clock);
            chk1($sformatf("lock%0d pin_incorrecto", k), inc_a, 1'b1);
            chk1($sformatf("lock%0d advertencia", k), adv_a, k == 1);
            chk1($sformatf("lock%0d bloqueo", k), blq_a, k == 2);
        end
        for (int i = 0; i < 100; i++) begin
            dstb_a    = i[0];
            mstb_a    = i[1];
            tarjeta_a = i[2];
            dig_a     = 4'(i);
            tipo_a    = i[3];
            monto_a   = 32'd1;
            tick();
            @(negedge clock);
            chk1($sformatf("locked bloqueo c%0d", i), blq_a, 1'b1);
            chk1($sformatf("locked quiet c%0d", i), act_a | ent_a | inc_a | fi_a, 1'b0);
        end
        dstb_a = 0; mstb_a = 0; tarjeta_a = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_lock reset outputs", {58'd0, act_a, ent_a, inc_a, adv_a, blq_a, fi_a}, 64'd0);
        chk("post_lock reset balance", bal_a, 64'd0);

        // Instance B: six-digit PIN and 16-bit balance wrap.
        bini_b    = 16'hFFF0;
        tarjeta_b = 1'b1;
        tick();
        digito_b(4'h9); digito_b(4'h8); digito_b(4'h7);
        digito_b(4'h6); digito_b(4'h5); digito_b(4'h4);
        tick();
        @(negedge clock);
        chk1("B pin_ok", inc_b, 1'b0);
        tipo_b  = DEPOSITO;
        monto_b = 16'd32;
        mstb_b  = 1'b1;
        tick();
        mstb_b = 1'b0;
        @(negedge clock);
        chk1("B latency1", act_b, 1'b0);
        tick();
        @(negedge clock);
        chk1("B actualizado", act_b, 1'b1);
        chk("B wrap balance", 64'(bal_b), 64'h0010);
        tarjeta_b = 1'b0;
        tick();
        @(negedge clock);
        chk1("B pulse_width", act_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
